// File: rtl/mips_core_pkg.sv
// ============================================================================
// Module   : mips_core_pkg
// Brief    : Shared branch-prediction types, counter constants and helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_core_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } branch_outcome_t;

    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t BP_CTR_INIT = 2'b01;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } bp_state_t;

    // Two-bit saturating step toward the resolved direction.
    function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input branch_outcome_t dir);
        bp_ctr_t nxt;
        nxt = ctr;
        if (dir == TAKEN) begin
            if (ctr != 2'b11) nxt = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_counter_table.sv
// ============================================================================
// Module   : bp_counter_table
// Brief    : 2^INDEX_WIDTH x 2-bit counters, async read, sync sweep/update write.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bp_counter_table
    import mips_core_pkg::*;
#(
    parameter int INDEX_WIDTH = 10
) (
    input  logic                   clk,
    input  logic [INDEX_WIDTH-1:0] i_rd_idx,
    output logic [1:0]             o_rd_ctr,
    input  logic                   i_clr_en,
    input  logic [INDEX_WIDTH-1:0] i_clr_idx,
    input  logic                   i_upd_en,
    input  logic [INDEX_WIDTH-1:0] i_upd_idx,
    input  logic                   i_upd_taken
);

    localparam int DEPTH = 1 << INDEX_WIDTH;

    bp_ctr_t         r_mem [0:DEPTH-1];
    bp_ctr_t         w_upd_cur;
    bp_ctr_t         w_upd_next;
    branch_outcome_t w_upd_dir;

    assign o_rd_ctr   = r_mem[i_rd_idx];
    assign w_upd_cur  = r_mem[i_upd_idx];
    assign w_upd_dir  = i_upd_taken ? TAKEN : NOT_TAKEN;
    assign w_upd_next = bp_ctr_next(w_upd_cur, w_upd_dir);

    // The sweep owns the write port; the top never raises both enables at once.
    always_ff @(posedge clk) begin
        if (i_clr_en) begin
            r_mem[i_clr_idx] <= BP_CTR_INIT;
        end else if (i_upd_en) begin
            r_mem[i_upd_idx] <= w_upd_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gshare_branch_predictor.sv
// ============================================================================
// Module   : gshare_branch_predictor
// Brief    : Gshare predictor with speculative GHR, mispredict repair and clear sweep.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gshare_branch_predictor
    import mips_core_pkg::*;
#(
    parameter int INDEX_WIDTH = 10,
    parameter int PC_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic                   req_stall,
    input  logic [PC_WIDTH-1:0]    req_pc,
    output logic                   pred_taken,
    output logic [INDEX_WIDTH-1:0] pred_ghr,
    input  logic                   upd_valid,
    input  logic [PC_WIDTH-1:0]    upd_pc,
    input  logic [INDEX_WIDTH-1:0] upd_ghr,
    input  logic                   upd_taken,
    input  logic                   upd_mispredict,
    output logic                   ready,
    output logic [31:0]            num_updates,
    output logic [31:0]            num_mispredicts
);

    bp_state_t              r_state;
    bp_state_t              w_state_next;
    logic [INDEX_WIDTH-1:0] r_ptr;
    logic [INDEX_WIDTH-1:0] r_ghr;
    logic [31:0]            r_num_upd;
    logic [31:0]            r_num_misp;

    logic                   w_ready;
    logic [INDEX_WIDTH-1:0] w_rd_idx;
    logic [INDEX_WIDTH-1:0] w_upd_idx;
    logic [1:0]             w_rd_ctr;
    branch_outcome_t        w_pred_dir;
    logic                   w_clr_en;
    logic                   w_upd_en;
    logic                   w_repair;
    logic                   w_spec_shift;
    logic                   w_unused_pc_bits;

    assign w_ready   = (r_state == ST_READY);
    assign w_rd_idx  = req_pc[INDEX_WIDTH+1:2] ^ r_ghr;
    assign w_upd_idx = upd_pc[INDEX_WIDTH+1:2] ^ upd_ghr;

    // PC bits outside the index field carry no information for the hash.
    assign w_unused_pc_bits = ^{req_pc[PC_WIDTH-1:INDEX_WIDTH+2], req_pc[1:0],
                                upd_pc[PC_WIDTH-1:INDEX_WIDTH+2], upd_pc[1:0]};

    assign w_clr_en     = (r_state == ST_CLEAR) & ~rst;
    assign w_upd_en     = w_ready & upd_valid & ~rst;
    assign w_repair     = w_ready & upd_valid & upd_mispredict;
    assign w_spec_shift = w_ready & req_valid & ~req_stall;

    bp_counter_table #(
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_table (
        .clk         (clk),
        .i_rd_idx    (w_rd_idx),
        .o_rd_ctr    (w_rd_ctr),
        .i_clr_en    (w_clr_en),
        .i_clr_idx   (r_ptr),
        .i_upd_en    (w_upd_en),
        .i_upd_idx   (w_upd_idx),
        .i_upd_taken (upd_taken)
    );

    // Table contents are undefined until the sweep completes, so force NOT_TAKEN.
    assign w_pred_dir = (w_ready && w_rd_ctr[1]) ? TAKEN : NOT_TAKEN;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CLEAR: begin
                if (r_ptr == {INDEX_WIDTH{1'b1}}) w_state_next = ST_READY;
            end
            ST_READY: w_state_next = ST_READY;
            default:  w_state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    // Repair outranks the speculative shift of a same-cycle request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (w_repair) begin
            r_ghr <= {upd_ghr[INDEX_WIDTH-2:0], upd_taken};
        end else if (w_spec_shift) begin
            r_ghr <= {r_ghr[INDEX_WIDTH-2:0], (w_pred_dir == TAKEN)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_upd  <= '0;
            r_num_misp <= '0;
        end else if (w_ready && upd_valid) begin
            r_num_upd <= r_num_upd + 32'd1;
            if (upd_mispredict) r_num_misp <= r_num_misp + 32'd1;
        end
    end

    assign pred_taken      = (w_pred_dir == TAKEN);
    assign pred_ghr        = r_ghr;
    assign ready           = w_ready;
    assign num_updates     = r_num_upd;
    assign num_mispredicts = r_num_misp;

endmodule

`default_nettype wire
